// File: rtl/branch_target_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup for the fetch PC is combinational; training, mispredict detection and perf counters work from EX.
module branch_target_predictor #(
  parameter int IDX_W = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredPCF,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] PCE,
  input  logic [31:0] BrTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  input  logic        StallE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [31:0] BranchCnt,
  output logic [31:0] MissCnt
);

  localparam int N     = 1 << IDX_W;
  localparam int TAG_W = 32 - IDX_W - 2;

  logic             valid_r  [N];
  logic [TAG_W-1:0] tag_r    [N];
  logic [31:0]      target_r [N];
  logic [1:0]       ctr_r    [N];

  logic [IDX_W-1:0] idx_f_s;
  logic [TAG_W-1:0] tag_f_s;
  logic             hit_f_s;
  logic [IDX_W-1:0] idx_e_s;
  logic [TAG_W-1:0] tag_e_s;
  logic             hit_e_s;
  logic             upd_s;
  logic             unused_s;

  // Saturating step of a 2-bit direction counter toward taken / not-taken.
  function automatic logic [1:0] ctr_step(input logic [1:0] ctr, input logic taken);
    logic [1:0] nxt;
    if (taken) begin
      nxt = (ctr == 2'b11) ? 2'b11 : ctr + 2'b01;
    end else begin
      nxt = (ctr == 2'b00) ? 2'b00 : ctr - 2'b01;
    end
    return nxt;
  endfunction

  // Instructions are word aligned, so the low PC bits carry no information.
  assign unused_s = ^{PCF[1:0], PCE[1:0]};

  // Fetch-side lookup and next-PC selection.
  always_comb begin
    idx_f_s    = PCF[IDX_W+1:2];
    tag_f_s    = PCF[31:IDX_W+2];
    hit_f_s    = valid_r[idx_f_s] && (tag_r[idx_f_s] == tag_f_s);
    PredTakenF = hit_f_s && ctr_r[idx_f_s][1];
    if (PredTakenF) begin
      PredPCF = target_r[idx_f_s];
    end else begin
      PredPCF = PCF + 32'd4;
    end
  end

  // EX-side hit detection, mispredict check and redirect target.
  always_comb begin
    idx_e_s     = PCE[IDX_W+1:2];
    tag_e_s     = PCE[31:IDX_W+2];
    hit_e_s     = valid_r[idx_e_s] && (tag_r[idx_e_s] == tag_e_s);
    upd_s       = (BranchTypeE != 3'b000) && !StallE;
    MispredictE = upd_s && ((BranchE != PredTakenE) ||
                            (BranchE && (PredTargetE != BrTargetE)));
    if (BranchE) begin
      RedirectPCE = BrTargetE;
    end else begin
      RedirectPCE = PCE + 32'd4;
    end
  end

  // Table training: hits move the counter, taken misses allocate, not-taken misses leave the table alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) begin
        valid_r[i]  <= 1'b0;
        tag_r[i]    <= '0;
        target_r[i] <= 32'd0;
        ctr_r[i]    <= 2'b01;
      end
    end else if (upd_s) begin
      if (hit_e_s) begin
        ctr_r[idx_e_s] <= ctr_step(ctr_r[idx_e_s], BranchE);
        if (BranchE) begin
          target_r[idx_e_s] <= BrTargetE;
        end
      end else if (BranchE) begin
        valid_r[idx_e_s]  <= 1'b1;
        tag_r[idx_e_s]    <= tag_e_s;
        target_r[idx_e_s] <= BrTargetE;
        ctr_r[idx_e_s]    <= 2'b10;
      end
    end
  end

  // Performance counters, free-running modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      BranchCnt <= 32'd0;
      MissCnt   <= 32'd0;
    end else if (upd_s) begin
      BranchCnt <= BranchCnt + 32'd1;
      if (MispredictE) begin
        MissCnt <= MissCnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed bench for branch_target_predictor: expectations are queued as stimulus is applied
// and popped when the corresponding output is sampled.
module tb_branch_target_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredPCF;
  logic [2:0]  BranchTypeE;
  logic        BranchE;
  logic [31:0] PCE;
  logic [31:0] BrTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        StallE;
  logic        MispredictE;
  logic [31:0] RedirectPCE;
  logic [31:0] BranchCnt;
  logic [31:0] MissCnt;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec;
  int   n_miss;
  int   exp_bc;
  int   exp_mc;

  branch_target_predictor #(.IDX_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .PCF(PCF), .PredTakenF(PredTakenF), .PredPCF(PredPCF),
    .BranchTypeE(BranchTypeE), .BranchE(BranchE), .PCE(PCE), .BrTargetE(BrTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .StallE(StallE),
    .MispredictE(MispredictE), .RedirectPCE(RedirectPCE),
    .BranchCnt(BranchCnt), .MissCnt(MissCnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push(input string t, input logic [31:0] v);
    exp_t e;
    e.tag = t;
    e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    n_vec++;
    if (sb_q.size() == 0) begin
      n_miss++;
      $error("FAIL sb_empty: observed %h expected <none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        n_miss++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic lookup(input logic [31:0] pc, input logic taken, input logic [31:0] npc);
    push($sformatf("taken@%h", pc), {31'd0, taken});
    push($sformatf("predpc@%h", pc), npc);
    PCF = pc;
    #1;
    chk({31'd0, PredTakenF});
    chk(PredPCF);
  endtask

  task automatic counters();
    push("branch_cnt", exp_bc);
    push("miss_cnt", exp_mc);
    chk(BranchCnt);
    chk(MissCnt);
  endtask

  // Apply one EX branch, check the combinational verdict, then clock it in.
  task automatic ex_branch(input logic [2:0] btype, input logic stall, input logic [31:0] pc,
                           input logic taken, input logic [31:0] tgt, input logic ptaken,
                           input logic [31:0] ptgt, input logic exp_mis, input logic [31:0] exp_rpc);
    push($sformatf("mispredict@%h", pc), {31'd0, exp_mis});
    push($sformatf("redirect@%h", pc), exp_rpc);
    BranchTypeE = btype; StallE = stall; PCE = pc; BranchE = taken;
    BrTargetE = tgt; PredTakenE = ptaken; PredTargetE = ptgt;
    #1;
    chk({31'd0, MispredictE});
    chk(RedirectPCE);
    @(posedge clk); #1;
    BranchTypeE = 3'b000; StallE = 1'b0; BranchE = 1'b0;
  endtask

  initial begin
    n_vec = 0; n_miss = 0; exp_bc = 0; exp_mc = 0;
    rst_n = 1'b0; PCF = 32'h40; BranchTypeE = 3'b000; BranchE = 1'b0; PCE = 32'd0;
    BrTargetE = 32'd0; PredTakenE = 1'b0; PredTargetE = 32'd0; StallE = 1'b0;
    #2;
    lookup(32'h40, 1'b0, 32'h44);
    counters();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // cold lookup, then first taken allocates
    lookup(32'h40, 1'b0, 32'h44);
    ex_branch(3'b001, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b1, 32'h100);
    counters();

    // counter saturation toward not-taken and back
    ex_branch(3'b001, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b0, 32'h44);
    ex_branch(3'b001, 1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
    ex_branch(3'b001, 1'b0, 32'h40, 1'b0, 32'h100, 1'b0, 32'h44, 1'b0, 32'h44);
    exp_bc += 2;
    lookup(32'h40, 1'b0, 32'h44);
    ex_branch(3'b001, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b0, 32'h44);
    ex_branch(3'b001, 1'b0, 32'h40, 1'b1, 32'h100, 1'b0, 32'h44, 1'b1, 32'h100);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b1, 32'h100);
    for (int i = 0; i < 5; i++) begin
      ex_branch(3'b001, 1'b0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
      exp_bc++;
    end
    ex_branch(3'b001, 1'b0, 32'h40, 1'b0, 32'h100, 1'b1, 32'h100, 1'b1, 32'h44);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b1, 32'h100);
    counters();

    // correct prediction, then alias eviction by a taken branch at the same index
    ex_branch(3'b001, 1'b0, 32'h40, 1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h100);
    exp_bc++;
    counters();
    ex_branch(3'b001, 1'b0, 32'h80, 1'b1, 32'h200, 1'b0, 32'h84, 1'b1, 32'h200);
    exp_bc++; exp_mc++;
    lookup(32'h40, 1'b0, 32'h44);
    lookup(32'h80, 1'b1, 32'h200);
    // not-taken alias does not evict
    ex_branch(3'b001, 1'b0, 32'hC0, 1'b0, 32'h600, 1'b0, 32'hC4, 1'b0, 32'hC4);
    exp_bc++;
    lookup(32'h80, 1'b1, 32'h200);
    // right direction, wrong target
    ex_branch(3'b001, 1'b0, 32'h80, 1'b1, 32'h300, 1'b1, 32'h200, 1'b1, 32'h300);
    exp_bc++; exp_mc++;
    lookup(32'h80, 1'b1, 32'h300);
    counters();

    // suppression: NOBRANCH and stalled EX
    ex_branch(3'b000, 1'b0, 32'h80, 1'b1, 32'h400, 1'b0, 32'h84, 1'b0, 32'h400);
    ex_branch(3'b010, 1'b1, 32'h80, 1'b1, 32'h400, 1'b0, 32'h84, 1'b0, 32'h400);
    lookup(32'h80, 1'b1, 32'h300);
    counters();

    // same-cycle lookup and update to the same entry: no bypass
    PCF = 32'hC0;
    push("nobypass_taken", 32'd0);
    #1;
    chk({31'd0, PredTakenF});
    ex_branch(3'b001, 1'b0, 32'hC0, 1'b1, 32'h500, 1'b0, 32'hC4, 1'b1, 32'h500);
    exp_bc++; exp_mc++;
    lookup(32'hC0, 1'b1, 32'h500);
    lookup(32'hFFFF_FFFC, 1'b0, 32'h0);
    counters();

    // async reset between edges
    PCF = 32'hC0;
    #2;
    rst_n = 1'b0;
    exp_bc = 0; exp_mc = 0;
    #1;
    lookup(32'hC0, 1'b0, 32'hC4);
    counters();
    #1;
    rst_n = 1'b1;

    if (sb_q.size() != 0) begin
      n_miss++;
      $error("FAIL sb_leftover: observed %0d expected 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
